// File: rtl/ps2_key_decoder_if.sv
// Byte-stream link from the PS/2 receiver into the key decoder.
// The receiver drives a byte plus a one-cycle valid strobe; there is no backpressure.
interface ps2_key_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: turns make/break/extended byte sequences into a
// start pulse for the title screen and held direction flags for the game screen.
module ps2_key_decoder #(
  parameter logic [7:0] START_CODE = 8'h5A,
  parameter logic [7:0] ALT_START  = 8'h29,
  parameter int         TIMEOUT    = 50000
) (
  input  logic               clock,
  input  logic               reset,
  ps2_key_decoder_if.slave   rx,
  output logic               o_start,
  output logic               o_key_up,
  output logic               o_key_down,
  output logic               o_key_left,
  output logic               o_key_right,
  output logic [7:0]         o_last_code,
  output logic               o_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GOT_E0   = 2'd1;
  localparam logic [1:0] S_GOT_F0   = 2'd2;
  localparam logic [1:0] S_GOT_E0F0 = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_startHeld;
  logic          r_start;
  logic          r_err;
  logic          r_up;
  logic          r_down;
  logic          r_left;
  logic          r_right;
  logic [7:0]    r_lastCode;

  logic [7:0] w_code;
  logic       w_isE0;
  logic       w_isF0;
  logic       w_isErr;
  logic       w_make;
  logic       w_break;
  logic       w_ext;
  logic [1:0] w_nextState;
  logic       w_isUp;
  logic       w_isDown;
  logic       w_isLeft;
  logic       w_isRight;
  logic       w_isStart;

  assign w_code  = rx.rx_data;
  assign w_isE0  = (w_code == 8'hE0);
  assign w_isF0  = (w_code == 8'hF0);
  assign w_isErr = (w_code == 8'h00) || (w_code == 8'hFF) || (w_code == 8'hAA);

  // Prefix tracking: decide whether the incoming byte is a prefix, a make or a break.
  always_comb begin
    w_make      = 1'b0;
    w_break     = 1'b0;
    w_ext       = 1'b0;
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_isE0)      w_nextState = S_GOT_E0;
        else if (w_isF0) w_nextState = S_GOT_F0;
        else             w_make = 1'b1;
      end
      S_GOT_E0: begin
        if (w_isF0)      w_nextState = S_GOT_E0F0;
        else if (!w_isE0) begin
          w_make      = 1'b1;
          w_ext       = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      S_GOT_F0: begin
        if (w_isE0)      w_nextState = S_GOT_E0;
        else if (!w_isF0) begin
          w_break     = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        if (!w_isE0 && !w_isF0) begin
          w_break     = 1'b1;
          w_ext       = 1'b1;
          w_nextState = S_IDLE;
        end
      end
    endcase
  end

  // Key matching: plain WASD codes or the extended arrow-key codes.
  always_comb begin
    w_isUp    = (w_code == 8'h1D && !w_ext) || (w_code == 8'h75 && w_ext);
    w_isDown  = (w_code == 8'h1B && !w_ext) || (w_code == 8'h72 && w_ext);
    w_isLeft  = (w_code == 8'h1C && !w_ext) || (w_code == 8'h6B && w_ext);
    w_isRight = (w_code == 8'h23 && !w_ext) || (w_code == 8'h74 && w_ext);
    w_isStart = (w_code == START_CODE) || (w_code == ALT_START && !w_ext);
  end

  // State, prefix timeout, held flags and the one-cycle start/err pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_startHeld <= 1'b0;
      r_start     <= 1'b0;
      r_err       <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_lastCode  <= 8'h00;
    end else begin
      r_start <= 1'b0;
      r_err   <= 1'b0;
      if (rx.rx_valid) begin
        r_count <= '0;
        if (w_isErr) begin
          r_err       <= 1'b1;
          r_up        <= 1'b0;
          r_down      <= 1'b0;
          r_left      <= 1'b0;
          r_right     <= 1'b0;
          r_startHeld <= 1'b0;
          r_state     <= S_IDLE;
        end else begin
          r_state <= w_nextState;
          if (w_make) begin
            if (w_isUp)    r_up    <= 1'b1;
            if (w_isDown)  r_down  <= 1'b1;
            if (w_isLeft)  r_left  <= 1'b1;
            if (w_isRight) r_right <= 1'b1;
            if (w_isStart && !r_startHeld) begin
              r_start     <= 1'b1;
              r_startHeld <= 1'b1;
            end
            r_lastCode <= w_code;
          end
          if (w_break) begin
            if (w_isUp)    r_up        <= 1'b0;
            if (w_isDown)  r_down      <= 1'b0;
            if (w_isLeft)  r_left      <= 1'b0;
            if (w_isRight) r_right     <= 1'b0;
            if (w_isStart) r_startHeld <= 1'b0;
            r_lastCode <= w_code;
          end
        end
      end else if (r_state != S_IDLE) begin
        if (r_count == TMAX) r_state <= S_IDLE;
        else                 r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_start     = r_start;
  assign o_err       = r_err;
  assign o_key_up    = r_up;
  assign o_key_down  = r_down;
  assign o_key_left  = r_left;
  assign o_key_right = r_right;
  assign o_last_code = r_lastCode;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of bytes with hand-computed
// outputs, followed by hand-written timeout and mid-sequence reset sequences.
module tb_ps2_key_decoder;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic       o_start, o_key_up, o_key_down, o_key_left, o_key_right, o_err;
  logic [7:0] o_last_code;

  int total = 0;
  int bad   = 0;

  ps2_key_decoder_if rxIf();

  ps2_key_decoder #(.TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rxIf),
    .o_start     (o_start),
    .o_key_up    (o_key_up),
    .o_key_down  (o_key_down),
    .o_key_left  (o_key_left),
    .o_key_right (o_key_right),
    .o_last_code (o_last_code),
    .o_err       (o_err)
  );

  // 100 MHz-style free-running clock.
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] code;
    logic       up, down, left, right, start, err;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[$];

  // Output order: {up, down, left, right, start, err, last_code}.
  localparam logic [13:0] PULSE_MASK = 14'h3CFF;

  function automatic logic [13:0] actualOut();
    return {o_key_up, o_key_down, o_key_left, o_key_right, o_start, o_err, o_last_code};
  endfunction

  function automatic logic [13:0] packExp(input logic u, d, l, r, s, e, input logic [7:0] c);
    return {u, d, l, r, s, e, c};
  endfunction

  task automatic addVec(input logic [7:0] code, input logic u, d, l, r, s, e,
                        input logic [7:0] last);
    vec_t v;
    v.code = code; v.up = u; v.down = d; v.left = l; v.right = r;
    v.start = s; v.err = e; v.last = last;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [13:0] expected);
    logic [13:0] got;
    got = actualOut();
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got {u,d,l,r,start,err,last}=%b_%b_%h required=%b_%b_%h",
               name, got[13:10], got[9:8], got[7:0],
               expected[13:10], expected[9:8], expected[7:0]);
    end
  endtask

  // Drive one byte with a one-cycle strobe and leave the bench just after the sampling edge.
  task automatic applyStimulus(input logic [7:0] code);
    @(negedge clock);
    rxIf.rx_data  = code;
    rxIf.rx_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // One quiet cycle after a byte: pulses must be gone, levels unchanged.
  task automatic idleCheck(input string name, input logic [13:0] expected);
    @(negedge clock);
    rxIf.rx_valid = 1'b0;
    @(posedge clock);
    #1;
    checkOutput(name, expected & PULSE_MASK);
  endtask

  task automatic byteAndCheck(input string name, input logic [7:0] code,
                              input logic [13:0] expected);
    applyStimulus(code);
    checkOutput(name, expected);
    idleCheck({name, "_idle"}, expected);
  endtask

  // Overall runtime guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rxIf.rx_data  = 8'h00;
    rxIf.rx_valid = 1'b0;

    // code  up dn lf rt st er last
    // 1: enter press, release
    addVec(8'h5A, 0,0,0,0,1,0, 8'h5A);
    addVec(8'hF0, 0,0,0,0,0,0, 8'h5A);
    addVec(8'h5A, 0,0,0,0,0,0, 8'h5A);
    // 2: typematic enter, release, then space
    addVec(8'h5A, 0,0,0,0,1,0, 8'h5A);
    addVec(8'h5A, 0,0,0,0,0,0, 8'h5A);
    addVec(8'h5A, 0,0,0,0,0,0, 8'h5A);
    addVec(8'hF0, 0,0,0,0,0,0, 8'h5A);
    addVec(8'h5A, 0,0,0,0,0,0, 8'h5A);
    addVec(8'h29, 0,0,0,0,1,0, 8'h29);
    // 3: extended up make/break, then W plus extended left
    addVec(8'hE0, 0,0,0,0,0,0, 8'h29);
    addVec(8'h75, 1,0,0,0,0,0, 8'h75);
    addVec(8'hE0, 1,0,0,0,0,0, 8'h75);
    addVec(8'hF0, 1,0,0,0,0,0, 8'h75);
    addVec(8'h75, 0,0,0,0,0,0, 8'h75);
    addVec(8'h1D, 1,0,0,0,0,0, 8'h1D);
    addVec(8'hE0, 1,0,0,0,0,0, 8'h1D);
    addVec(8'h6B, 1,0,1,0,0,0, 8'h6B);
    // 5: hold D, then AA clears everything but last_code
    addVec(8'h23, 1,0,1,1,0,0, 8'h23);
    addVec(8'hAA, 0,0,0,0,0,1, 8'h23);
    // err also cleared start-held: space pulses again, then release it
    addVec(8'h29, 0,0,0,0,1,0, 8'h29);
    addVec(8'hF0, 0,0,0,0,0,0, 8'h29);
    addVec(8'h29, 0,0,0,0,0,0, 8'h29);
    // FF after a prefix drops the prefix: 72 is then a plain unknown code
    addVec(8'hE0, 0,0,0,0,0,0, 8'h29);
    addVec(8'hFF, 0,0,0,0,0,1, 8'h29);
    addVec(8'h72, 0,0,0,0,0,0, 8'h72);
    // keypad enter (E0 5A) is a start key; E0 29 is not
    addVec(8'hE0, 0,0,0,0,0,0, 8'h72);
    addVec(8'h5A, 0,0,0,0,1,0, 8'h5A);
    addVec(8'hE0, 0,0,0,0,0,0, 8'h5A);
    addVec(8'hF0, 0,0,0,0,0,0, 8'h5A);
    addVec(8'h5A, 0,0,0,0,0,0, 8'h5A);
    addVec(8'hE0, 0,0,0,0,0,0, 8'h5A);
    addVec(8'h29, 0,0,0,0,0,0, 8'h29);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_state", 14'h0000);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("after_reset_release", 14'h0000);

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      byteAndCheck($sformatf("vec%0d_%h", i, vecs[i].code), vecs[i].code,
                   packExp(vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right,
                           vecs[i].start, vecs[i].err, vecs[i].last));
    end

    // 4: F0 left hanging past the timeout, so 1B is a make
    byteAndCheck("to_f0", 8'hF0, packExp(0,0,0,0,0,0, 8'h29));
    repeat (20) @(posedge clock);
    #1;
    checkOutput("to_wait", packExp(0,0,0,0,0,0, 8'h29));
    byteAndCheck("to_make_1b", 8'h1B, packExp(0,1,0,0,0,0, 8'h1B));
    // A short gap keeps the prefix, so 1B is a break
    byteAndCheck("short_f0", 8'hF0, packExp(0,1,0,0,0,0, 8'h1B));
    repeat (3) @(posedge clock);
    #1;
    byteAndCheck("short_break_1b", 8'h1B, packExp(0,0,0,0,0,0, 8'h1B));

    // 6: reset after E0 F0, strobe during reset is dropped, then 74 is a make
    byteAndCheck("rs_1d", 8'h1D, packExp(1,0,0,0,0,0, 8'h1D));
    byteAndCheck("rs_e0", 8'hE0, packExp(1,0,0,0,0,0, 8'h1D));
    byteAndCheck("rs_f0", 8'hF0, packExp(1,0,0,0,0,0, 8'h1D));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rs_in_reset", 14'h0000);
    applyStimulus(8'h74);
    checkOutput("rs_strobe_dropped", 14'h0000);
    @(negedge clock);
    rxIf.rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rs_released", 14'h0000);
    byteAndCheck("rs_make_74", 8'h74, packExp(0,0,0,0,0,0, 8'h74));
    byteAndCheck("rs_e0_74_e0", 8'hE0, packExp(0,0,0,0,0,0, 8'h74));
    byteAndCheck("rs_e0_74", 8'h74, packExp(0,0,0,1,0,0, 8'h74));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
